// File: rtl/dbg_pkg.sv
// Shared debug-unit constants: latch selects, ready marker, dump FSM encoding.
// DUMP_CHECKSUM_EN adds the checksum states to the encoding.
package dbg_pkg;

    localparam logic [1:0] SEL_IF_ID  = 2'd0;
    localparam logic [1:0] SEL_ID_EX  = 2'd1;
    localparam logic [1:0] SEL_EX_MEM = 2'd2;
    localparam logic [1:0] SEL_MEM_WB = 2'd3;

    localparam logic [7:0] READY_CHAR = 8'h52;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND      = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
    localparam logic [2:0] S_MARK      = 3'd3;
    localparam logic [2:0] S_MARK_WAIT = 3'd4;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] S_CSUM      = 3'd5;
    localparam logic [2:0] S_CSUM_WAIT = 3'd6;
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_SEND      = S_SEND,
        ST_WAIT      = S_WAIT,
        ST_MARK      = S_MARK,
        ST_MARK_WAIT = S_MARK_WAIT
`ifdef DUMP_CHECKSUM_EN
        ,
        ST_CSUM      = S_CSUM,
        ST_CSUM_WAIT = S_CSUM_WAIT
`endif
    } dump_state_t;

    function automatic int nbytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/latch_dump_sequencer_if.sv
// Command-decoder and uart_tx handshake of the latch dump sequencer.
interface latch_dump_sequencer_if;
    logic       i_req;
    logic [1:0] i_sel;
    logic       i_tx_done;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_req, i_sel, i_tx_done,
        input  o_tx_data, o_tx_start, o_busy, o_done
    );

    modport slave (
        input  i_req, i_sel, i_tx_done,
        output o_tx_data, o_tx_start, o_busy, o_done
    );
endinterface

// File: rtl/byte_mux_snapshot.sv
// Captures the selected pipeline latch zero-extended to whole bytes and
// returns the byte addressed by i_idx (LSB byte at index 0).
module byte_mux_snapshot
    import dbg_pkg::*;
#(
    parameter int IF_ID_SIZE  = 64,
    parameter int ID_EX_SIZE  = 129,
    parameter int EX_MEM_SIZE = 78,
    parameter int MEM_WB_SIZE = 72
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_capture,
    input  logic [1:0]             i_sel,
    input  logic [IF_ID_SIZE-1:0]  i_if_id,
    input  logic [ID_EX_SIZE-1:0]  i_id_ex,
    input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
    input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
    input  logic [4:0]             i_idx,
    output logic [7:0]             o_byte
);
    localparam int MAX_A  = (IF_ID_SIZE > ID_EX_SIZE) ? IF_ID_SIZE : ID_EX_SIZE;
    localparam int MAX_B  = (EX_MEM_SIZE > MEM_WB_SIZE) ? EX_MEM_SIZE : MEM_WB_SIZE;
    localparam int MAX_W  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int SNAP_W = 8 * nbytes(MAX_W);

    logic [SNAP_W-1:0] snap;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            snap <= '0;
        end else if (i_capture) begin
            case (i_sel)
                SEL_IF_ID:  snap <= SNAP_W'(i_if_id);
                SEL_ID_EX:  snap <= SNAP_W'(i_id_ex);
                SEL_EX_MEM: snap <= SNAP_W'(i_ex_mem);
                default:    snap <= SNAP_W'(i_mem_wb);
            endcase
        end
    end

    // Indices past the snapshot shift in zeros rather than wrapping.
    assign o_byte = 8'(snap >> {i_idx, 3'b000});

endmodule

// File: rtl/latch_dump_sequencer.sv
// Serializes one snapshotted pipeline latch to uart_tx, LSB byte first,
// followed by the ready marker. DUMP_CHECKSUM_EN inserts an XOR checksum byte.
//
// state     | meaning
// IDLE      | waiting for a dump request
// SEND      | load data byte idx, pulse tx start
// WAIT      | hold byte until uart reports done
// CSUM      | load XOR checksum, pulse tx start (checksum build only)
// CSUM_WAIT | hold checksum until done (checksum build only)
// MARK      | load ready marker, pulse tx start
// MARK_WAIT | hold marker until done, then signal completion
module latch_dump_sequencer #(
    parameter int         IF_ID_SIZE  = 64,
    parameter int         ID_EX_SIZE  = 129,
    parameter int         EX_MEM_SIZE = 78,
    parameter int         MEM_WB_SIZE = 72,
    parameter logic [7:0] READY_CHAR  = dbg_pkg::READY_CHAR
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [IF_ID_SIZE-1:0]  i_if_id,
    input  logic [ID_EX_SIZE-1:0]  i_id_ex,
    input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
    input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
    latch_dump_sequencer_if.slave  dbg
);
    import dbg_pkg::*;

    localparam logic [4:0] LEN_IF_ID  = 5'(nbytes(IF_ID_SIZE));
    localparam logic [4:0] LEN_ID_EX  = 5'(nbytes(ID_EX_SIZE));
    localparam logic [4:0] LEN_EX_MEM = 5'(nbytes(EX_MEM_SIZE));
    localparam logic [4:0] LEN_MEM_WB = 5'(nbytes(MEM_WB_SIZE));

    dump_state_t state, state_nxt;
    logic [4:0]  idx, idx_nxt, len, len_nxt;
    logic        busy_q, busy_nxt, done_q, done_nxt, start_q, start_nxt, capture;
    logic [7:0]  data_q, data_nxt, snap_byte;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]  csum_q, csum_nxt;
`endif

    byte_mux_snapshot #(
        .IF_ID_SIZE (IF_ID_SIZE),
        .ID_EX_SIZE (ID_EX_SIZE),
        .EX_MEM_SIZE(EX_MEM_SIZE),
        .MEM_WB_SIZE(MEM_WB_SIZE)
    ) u_snap (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_capture(capture),
        .i_sel    (dbg.i_sel),
        .i_if_id  (i_if_id),
        .i_id_ex  (i_id_ex),
        .i_ex_mem (i_ex_mem),
        .i_mem_wb (i_mem_wb),
        .i_idx    (idx),
        .o_byte   (snap_byte)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        start_nxt = 1'b0;
        data_nxt  = data_q;
        capture   = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        csum_nxt  = csum_q;
`endif
        case (state)
            ST_IDLE: begin
                // done_q still high means the marker just finished; that cycle's request is dropped
                if (dbg.i_req && !done_q) begin
                    capture  = 1'b1;
                    idx_nxt  = 5'd0;
                    busy_nxt = 1'b1;
                    case (dbg.i_sel)
                        SEL_IF_ID:  len_nxt = LEN_IF_ID;
                        SEL_ID_EX:  len_nxt = LEN_ID_EX;
                        SEL_EX_MEM: len_nxt = LEN_EX_MEM;
                        default:    len_nxt = LEN_MEM_WB;
                    endcase
`ifdef DUMP_CHECKSUM_EN
                    csum_nxt = 8'h00;
`endif
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                data_nxt  = snap_byte;
                start_nxt = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                csum_nxt  = csum_q ^ snap_byte;
`endif
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (dbg.i_tx_done) begin
                    if (idx == len - 5'd1) begin
`ifdef DUMP_CHECKSUM_EN
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_MARK;
`endif
                    end else begin
                        idx_nxt   = idx + 5'd1;
                        state_nxt = ST_SEND;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CSUM: begin
                data_nxt  = csum_q;
                start_nxt = 1'b1;
                state_nxt = ST_CSUM_WAIT;
            end
            ST_CSUM_WAIT: begin
                if (dbg.i_tx_done) state_nxt = ST_MARK;
            end
`endif
            ST_MARK: begin
                data_nxt  = READY_CHAR;
                start_nxt = 1'b1;
                state_nxt = ST_MARK_WAIT;
            end
            ST_MARK_WAIT: begin
                if (dbg.i_tx_done) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs give the 2-cycle request latency and one idle cycle after tx done.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx     <= 5'd0;
            len     <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            idx     <= idx_nxt;
            len     <= len_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            start_q <= start_nxt;
            data_q  <= data_nxt;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= csum_nxt;
`endif
        end
    end

    assign dbg.o_tx_data  = data_q;
    assign dbg.o_tx_start = start_q;
    assign dbg.o_busy     = busy_q;
    assign dbg.o_done     = done_q;

endmodule

// File: tb/tb_latch_dump_sequencer.sv
// Scoreboard bench for latch_dump_sequencer; honours DUMP_CHECKSUM_EN when defined.
module tb_latch_dump_sequencer;
    import dbg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0]  if_id;
    logic [128:0] id_ex;
    logic [77:0]  ex_mem;
    logic [71:0]  mem_wb;

    latch_dump_sequencer_if bus();

    latch_dump_sequencer dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_if_id (if_id),
        .i_id_ex (id_ex),
        .i_ex_mem(ex_mem),
        .i_mem_wb(mem_wb),
        .dbg     (bus)
    );

    int         checks  = 0;
    int         errors  = 0;
    int         cyc     = 0;
    int         n_start = 0;
    int         pend    = 0;
    int         lat_exp = 0;
    bit         lat_pend = 1'b0;
    logic [8:0] exp_q[$];
`ifdef DUMP_CHECKSUM_EN
    logic [7:0] exp_csum;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // uart_tx model: byte-complete pulse 20 cycles after each start
    always @(negedge clk) begin
        bus.i_tx_done = 1'b0;
        if (rst) pend = 0;
        else if (bus.o_tx_start) pend = 20;
        else if (pend > 0) begin
            pend--;
            if (pend == 0) bus.i_tx_done = 1'b1;
        end
    end

    // Monitor: pop expected entry whenever the DUT starts a byte or signals done
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            if (bus.o_tx_start) begin
                n_start++;
                if (lat_pend) begin
                    check("start_latency", cyc, lat_exp);
                    lat_pend = 1'b0;
                end
                if (exp_q.size() == 0) check("unexpected_start", {24'd0, bus.o_tx_data}, 32'h1ff);
                else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {23'd0, 1'b0, bus.o_tx_data}, {23'd0, e});
                end
            end
            if (bus.o_done) begin
                if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("done_event", 32'h100, {23'd0, e});
                end
            end
            if (bus.i_req && !bus.o_busy && !bus.o_done) begin
                lat_pend = 1'b1;
                lat_exp  = cyc + 2;
            end
        end
    end

    task automatic exp_begin();
`ifdef DUMP_CHECKSUM_EN
        exp_csum = 8'h00;
`endif
    endtask

    task automatic exp_byte(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
`ifdef DUMP_CHECKSUM_EN
        exp_csum = exp_csum ^ b;
`endif
    endtask

    task automatic exp_end();
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back({1'b0, exp_csum});
`endif
        exp_q.push_back({1'b0, READY_CHAR});
        exp_q.push_back(9'h100);
    endtask

    task automatic dump_req(input logic [1:0] s);
        @(posedge clk); #1;
        bus.i_sel = s;
        bus.i_req = 1'b1;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit busy_chk);
        bit seen    = 1'b0;
        bit dropped = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
            else if (busy_chk && !bus.o_busy) dropped = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (busy_chk) check("busy_hold", {31'd0, dropped}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_data"}, {24'd0, bus.o_tx_data}, 32'd0);
        check({tag, "_tx_start"}, {31'd0, bus.o_tx_start}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.o_done}, 32'd0);
    endtask

    initial begin
        int base;
        bit seen;
        rst       = 1'b1;
        bus.i_req = 1'b0;
        bus.i_sel = 2'd0;
        if_id     = '0;
        id_ex     = '0;
        ex_mem    = '0;
        mem_wb    = '0;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // IF/ID basic stream
        if_id = 64'h0123_4567_89AB_CDEF;
        exp_begin();
        exp_byte(8'hEF); exp_byte(8'hCD); exp_byte(8'hAB); exp_byte(8'h89);
        exp_byte(8'h67); exp_byte(8'h45); exp_byte(8'h23); exp_byte(8'h01);
        exp_end();
        dump_req(SEL_IF_ID);
        wait_done(1000, 1'b1);
        @(negedge clk);
        check("q_empty_if_id", exp_q.size(), 0);

        // ID/EX top bit only: 17 bytes, upper pad zero
        id_ex = '0;
        id_ex[128] = 1'b1;
        exp_begin();
        for (int i = 0; i < 16; i++) exp_byte(8'h00);
        exp_byte(8'h01);
        exp_end();
        dump_req(SEL_ID_EX);
        wait_done(1000, 1'b1);
        @(negedge clk);
        check("q_empty_id_ex", exp_q.size(), 0);

        // EX/MEM changing every cycle after acceptance
        ex_mem = 78'h2A_BEEF_0011_2233_4455_66;
        exp_begin();
        exp_byte(8'h66); exp_byte(8'h55); exp_byte(8'h44); exp_byte(8'h33); exp_byte(8'h22);
        exp_byte(8'h11); exp_byte(8'h00); exp_byte(8'hEF); exp_byte(8'hBE); exp_byte(8'h2A);
        exp_end();
        dump_req(SEL_EX_MEM);
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
            ex_mem = {ex_mem[76:0], ~ex_mem[77]};
        end
        check("done_seen_ex_mem", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("q_empty_ex_mem", exp_q.size(), 0);

        // MEM/WB with a second request during WAIT and one on the done cycle
        mem_wb = 72'h11_2233_4455_6677_8899;
        exp_begin();
        exp_byte(8'h99); exp_byte(8'h88); exp_byte(8'h77); exp_byte(8'h66); exp_byte(8'h55);
        exp_byte(8'h44); exp_byte(8'h33); exp_byte(8'h22); exp_byte(8'h11);
        exp_end();
        dump_req(SEL_MEM_WB);
        repeat (30) @(posedge clk);
        #1 bus.i_sel = SEL_IF_ID;
        bus.i_req = 1'b1;
        @(posedge clk); #1 bus.i_req = 1'b0;
        wait_done(1000, 1'b1);
        bus.i_sel = SEL_ID_EX;
        bus.i_req = 1'b1;
        @(posedge clk); #1 bus.i_req = 1'b0;
        base = n_start;
        repeat (60) @(posedge clk);
        check("req_on_done_ignored", n_start, base);
        check("q_empty_mem_wb", exp_q.size(), 0);

        // Reset after the third IF/ID byte, then a full fresh dump
        if_id = 64'hFEDC_BA98_7654_3210;
        exp_q.push_back(9'h010); exp_q.push_back(9'h032); exp_q.push_back(9'h054);
        base = n_start;
        dump_req(SEL_IF_ID);
        for (int k = 0; k < 500 && (n_start - base) < 3; k++) @(posedge clk);
        check("third_byte_reached", n_start - base, 3);
        #1 rst = 1'b1;
        #1 check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base = n_start;
        repeat (60) @(posedge clk);
        check("no_mark_after_reset", n_start, base);
        check("q_empty_reset", exp_q.size(), 0);
        exp_begin();
        exp_byte(8'h10); exp_byte(8'h32); exp_byte(8'h54); exp_byte(8'h76);
        exp_byte(8'h98); exp_byte(8'hBA); exp_byte(8'hDC); exp_byte(8'hFE);
        exp_end();
        dump_req(SEL_IF_ID);
        wait_done(1000, 1'b1);
        @(negedge clk);
        check("q_empty_fresh", exp_q.size(), 0);

`ifdef DUMP_CHECKSUM_EN
        // Checksum byte: 0F^0F = 00, then a single 01 byte gives 01
        if_id = 64'h0000_0000_0000_0F0F;
        exp_q.push_back(9'h00F); exp_q.push_back(9'h00F);
        for (int i = 0; i < 6; i++) exp_q.push_back(9'h000);
        exp_q.push_back(9'h000); exp_q.push_back(9'h052); exp_q.push_back(9'h100);
        dump_req(SEL_IF_ID);
        wait_done(1000, 1'b1);
        @(negedge clk);
        check("q_empty_csum0", exp_q.size(), 0);
        if_id = 64'h1;
        exp_q.push_back(9'h001);
        for (int i = 0; i < 7; i++) exp_q.push_back(9'h000);
        exp_q.push_back(9'h001); exp_q.push_back(9'h052); exp_q.push_back(9'h100);
        dump_req(SEL_IF_ID);
        wait_done(1000, 1'b1);
        @(negedge clk);
        check("q_empty_csum1", exp_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
